axi4_lite_lsu_master: RTL
=========================

Name: axi4_lite_lsu_master

Overview:
AXI4-Lite master that turns the CPU load/store unit's single-request memory port into AXI4-Lite read or write transactions. It sits directly upstream of the AXI4-Lite BRAM slave and drives its AW/W/B/AR/R channels. It holds one transaction in flight, stalls the LSU until that transaction completes, and returns load data and response status.

Parameters:
ADDR_W, 32, byte-address width on both CPU and AXI sides
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
MEM_REQ  in  1  LSU request; sampled only when MEM_READY=1
MEM_WE  in  1  1 = store, 0 = load
MEM_ADDR  in  ADDR_W  byte address
MEM_WDATA  in  DATA_W  store data, already lane-aligned
MEM_WSTRB  in  DATA_W/8  store byte enables; ignored for loads
MEM_READY  out  1  block idle and able to accept a request (LSU stall = ~MEM_READY)
MEM_DONE  out  1  one-cycle completion pulse
MEM_RDATA  out  DATA_W  load data, valid when MEM_DONE follows a load
MEM_ERR  out  1  response was not OKAY, valid with MEM_DONE
AW_VALID/AW_READY/AW_ADDR  out/in/out  1/1/ADDR_W  write address channel
W_VALID/W_READY/W_DATA/W_STRB  out/in/out/out  1/1/DATA_W/DATA_W/8  write data channel
B_VALID/B_READY/B_RESP  in/out/in  1/1/2  write response channel
AR_VALID/AR_READY/AR_ADDR  out/in/out  1/1/ADDR_W  read address channel
R_VALID/R_READY/R_DATA/R_RESP  in/out/in/in  1/1/DATA_W/2  read data channel

Behaviour:
- Reset: the block is clocked on ACLK and reset asynchronously by ARESETn (active-low).
- Reset values: all VALID/READY outputs 0, MEM_DONE 0, MEM_ERR 0, MEM_RDATA 0, FSM in IDLE.
- Reset mid-transaction drops all VALIDs immediately and issues no MEM_DONE.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- MEM_READY is combinational and equals (state==IDLE). It is 1 during reset; the LSU must not request during reset.
- Acceptance (MEM_REQ & MEM_READY): MEM_ADDR, MEM_WDATA and MEM_WSTRB are registered. AXI addresses are word-aligned: {addr[ADDR_W-1:2], 2'b00}.
- Store with MEM_WSTRB != 0: go to WR_REQ. AW_VALID and W_VALID both rise the next cycle.
  - Each VALID falls the cycle after its own handshake; AW and W may complete in either order or the same cycle. Done-flags track each.
  - Address, data and strobe stay stable while the corresponding VALID is high.
  - When both handshakes are done, go to WR_RESP with B_READY=1.
- Store with MEM_WSTRB == 0: no AXI traffic; MEM_DONE=1 the next cycle with MEM_ERR=0. The slave issues no B response for an empty strobe, so this path is mandatory.
- Load: go to RD_REQ; AR_VALID rises the next cycle and is held with a stable address until AR_READY. Then go to RD_RESP with R_READY=1.
- Completion:
  - On the B or R handshake in cycle k, MEM_DONE=1 in cycle k+1, state returns to IDLE, and MEM_ERR=(resp!=2'b00).
  - On a read, MEM_RDATA<=R_DATA. MEM_RDATA holds until the next load completes; stores do not change it.
- Back-to-back: a new request is accepted in the same cycle MEM_DONE is high (state already IDLE).
- Unsolicited B_VALID or R_VALID while the block is not waiting for it: READY stays 0, it is ignored, and no state change occurs.
- Minimum latency, acceptance to MEM_DONE, with zero-wait handshakes: load 3 cycles (AR hs c1, R hs c2, DONE c3); store 3 cycles (AW/W hs c1, B hs c2, DONE c3). Slave wait states add cycles one-for-one.

Decomposition:
- ADDR_W, DATA_W and the AXI response encodings (OKAY=2'b00, SLVERR=2'b10) go in the shared SYSTEM_DEF.vh. The FSM state encoding stays local.
- No sub-module; a single FSM with two write-channel done-flags.

Test Plan:
- Load 0x0000_0104, slave AR_READY=1, R_DATA=0xDEAD_BEEF, R_RESP=0 -> AR_ADDR=0x104, MEM_DONE in cycle 3, MEM_RDATA=0xDEADBEEF, MEM_ERR=0.
- Store addr 0x0000_0012, data 0x0000_AB00, strb 4'b0010; slave AW_READY=1 but W_READY delayed 3 cycles -> AW_ADDR=0x10; AW_VALID drops after 1 cycle; W held stable 4 cycles; B_READY only after the W handshake; a single MEM_DONE.
- Store with strb 4'b0000 -> no AW_VALID or W_VALID ever; MEM_DONE exactly 1 cycle after acceptance.
- B_RESP=2'b10 on a store -> MEM_ERR=1 with MEM_DONE. A following load returning OKAY -> MEM_ERR=0 and MEM_RDATA updated.
- Back-to-back load, store, load with MEM_REQ held high -> each request accepted in its predecessor's MEM_DONE cycle; three DONE pulses; no channel overlap.
- ARESETn pulsed low while AR_VALID=1 and the slave stalls -> AR_VALID=0 asynchronously, no MEM_DONE; after reset MEM_READY=1 and a new load completes normally.

Source files
------------

// File: rtl/axi4_lite_lsu_master_pkg.sv
// Shared definitions for the LSU-side AXI4-Lite master: bus widths and AXI response encodings.
package axi4_lite_lsu_master_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AxiRespOkay   = 2'b00;
  localparam axi_resp_t AxiRespSlvErr = 2'b10;

  function automatic logic resp_is_err(axi_resp_t resp);
    return resp != AxiRespOkay;
  endfunction

endpackage

// File: rtl/axi4_lite_lsu_master.sv
// AXI4-Lite master bridging the LSU's single-request memory port onto AW/W/B/AR/R.
// One transaction in flight; the LSU is stalled (MEM_READY=0) until it completes.
module axi4_lite_lsu_master
  import axi4_lite_lsu_master_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                MEM_REQ,
  input  logic                MEM_WE,
  input  logic [ADDR_W-1:0]   MEM_ADDR,
  input  logic [DATA_W-1:0]   MEM_WDATA,
  input  logic [DATA_W/8-1:0] MEM_WSTRB,
  output logic                MEM_READY,
  output logic                MEM_DONE,
  output logic [DATA_W-1:0]   MEM_RDATA,
  output logic                MEM_ERR,
  output logic                AW_VALID,
  input  logic                AW_READY,
  output logic [ADDR_W-1:0]   AW_ADDR,
  output logic                W_VALID,
  input  logic                W_READY,
  output logic [DATA_W-1:0]   W_DATA,
  output logic [DATA_W/8-1:0] W_STRB,
  input  logic                B_VALID,
  output logic                B_READY,
  input  logic [1:0]          B_RESP,
  output logic                AR_VALID,
  input  logic                AR_READY,
  output logic [ADDR_W-1:0]   AR_ADDR,
  input  logic                R_VALID,
  output logic                R_READY,
  input  logic [DATA_W-1:0]   R_DATA,
  input  logic [1:0]          R_RESP
);

  localparam int unsigned StrbW = DATA_W / 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp
  } state_e;

  state_e              state_q, state_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (MEM_REQ) begin
          addr_d    = MEM_ADDR & ~(ADDR_W'(3));
          wdata_d   = MEM_WDATA;
          wstrb_d   = MEM_WSTRB;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (!MEM_WE) begin
            state_d = StRdReq;
          end else if (MEM_WSTRB != '0) begin
            state_d = StWrReq;
          end else begin
            // The slave never answers an empty-strobe write, so complete it locally.
            done_d = 1'b1;
            err_d  = 1'b0;
          end
        end
      end
      StWrReq: begin
        aw_done_d = aw_done_q | (AW_VALID & AW_READY);
        w_done_d  = w_done_q | (W_VALID & W_READY);
        if (aw_done_d && w_done_d) begin
          state_d = StWrResp;
        end
      end
      StWrResp: begin
        if (B_VALID) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = resp_is_err(B_RESP);
        end
      end
      StRdReq: begin
        if (AR_READY) begin
          state_d = StRdResp;
        end
      end
      StRdResp: begin
        if (R_VALID) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = resp_is_err(R_RESP);
          rdata_d = R_DATA;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // All channel controls decode straight from registered state, so reset drops them at once.
  assign MEM_READY = (state_q == StIdle);
  assign MEM_DONE  = done_q;
  assign MEM_ERR   = err_q;
  assign MEM_RDATA = rdata_q;

  assign AW_VALID  = (state_q == StWrReq) && !aw_done_q;
  assign W_VALID   = (state_q == StWrReq) && !w_done_q;
  assign B_READY   = (state_q == StWrResp);
  assign AR_VALID  = (state_q == StRdReq);
  assign R_READY   = (state_q == StRdResp);

  assign AW_ADDR   = addr_q;
  assign AR_ADDR   = addr_q;
  assign W_DATA    = wdata_q;
  assign W_STRB    = wstrb_q;

endmodule
